pad_in_deglitch: RTL and testbench
==================================

Name: pad_in_deglitch

Overview:
- Core-side stage directly downstream of the digital input IO cell. Takes the cell's raw `i` output, which is asynchronous to the core clock.
- Synchronizes the signal, then optionally qualifies it with a programmable stability filter.
- Delivers a clean level plus single-cycle rise/fall pulses to core logic such as a UART RX or a TL bringup controller.
- Counts rejected glitches as a saturating counter for bringup observability.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchronizer chain (legal ≥2).
- CNT_W, 8, width of stability threshold and qualify counter.
- GLITCH_W, 8, width of the saturating glitch counter.
- RESET_VAL, 1, reset level of the sync chain and `out` (1 = UART idle-high).

Ports:
- clock  input  1  core clock.
- reset_n  input  1  synchronous reset, active-low.
- i  input  1  raw pad level from the IO cell; asynchronous.
- filt_en  input  1  1 = stability filter active; 0 = bypass (sync only).
- stable_cycles  input  CNT_W  consecutive cycles of disagreement required to accept a new level; 0 is treated as 1.
- glitch_clr  input  1  synchronous clear of glitch_cnt.
- out  output  1  filtered level.
- rise  output  1  one-cycle pulse when out goes 0→1.
- fall  output  1  one-cycle pulse when out goes 1→0.
- glitch_cnt  output  GLITCH_W  saturating count of aborted qualifications.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All sync flops and out = RESET_VAL; rise = fall = 0; glitch_cnt = 0; cnt = 0; state = STABLE.
  - Reset asserted mid-QUALIFY aborts the qualification with no glitch count and no pulse.
- Synchronizer:
  - sync[0] <= i, sync[n] <= sync[n-1].
  - s = sync[SYNC_STAGES-1].
  - No logic between sync stages.
- Effective threshold: thr = (stable_cycles==0) ? 1 : stable_cycles.
- Bypass (filt_en=0):
  - out <= s every cycle; state forced to STABLE; cnt <= 0; glitch_cnt unchanged.
  - Latency from i change to out change = SYNC_STAGES+1 edges.
- Filter (filt_en=1), two states:
  - STABLE:
    - If s==out, hold.
    - If s!=out and thr==1: out <= s this edge; stay STABLE.
    - If s!=out and thr>1: cnt <= 1, go to QUALIFY.
  - QUALIFY:
    - If s==out (glitch): cnt <= 0; go to STABLE; glitch_cnt increments by 1, saturating at all-ones.
    - Else if cnt+1 ≥ thr: out <= s; cnt <= 0; go to STABLE.
    - Else cnt <= cnt+1.
  - Latency from i change to out change = SYNC_STAGES+thr edges for a clean edge.
- stable_cycles changes mid-QUALIFY:
  - The comparison uses the current value every cycle.
  - If the current cnt+1 already meets the new thr, out updates on that edge.
- filt_en falls mid-QUALIFY: abort and enter bypass the same edge. out <= s; no glitch count.
- filt_en rises: the filter starts from STABLE with cnt=0 on the following edge.
- rise/fall:
  - Registered, computed from the same update as out.
  - rise=1 exactly in the first cycle out shows 1 after a 0; fall likewise for 1→0.
  - Never both high at once.
  - Deasserted the next cycle unless out toggles again; back-to-back toggles are possible only in bypass or with thr=1.
- glitch_cnt:
  - glitch_clr=1 sets it to 0 and has priority over a simultaneous increment.
  - Holds at 2^GLITCH_W-1 once saturated.
- cnt never exceeds thr-1 and never wraps.

Test Plan:
- Reset release, i=1 held: out=1, rise=fall=0, glitch_cnt=0 for all cycles; repeat with RESET_VAL=0 and i=0.
- Bypass, i 1→0 before edge k: out=0 and fall=1 visible after edge k+2 (SYNC_STAGES=2); fall low the next cycle.
- filt_en=1, stable_cycles=4, i 1→0 held: out falls after exactly 2+4 edges with a single fall pulse. The reverse 0→1 gives the same latency with a rise pulse.
- filt_en=1, stable_cycles=4, i low for 3 cycles then back high: out stays 1, no pulses, glitch_cnt=1. Repeating 300 times gives glitch_cnt=255 (saturated). glitch_clr asserted on the same edge as a glitch gives glitch_cnt=0.
- stable_cycles=0 vs 1: identical timing (out after 2+1 edges). Lowering stable_cycles from 8 to 2 while cnt=3 makes out update on the next edge.
- Mid-QUALIFY events: reset_n=0 gives out=RESET_VAL and glitch_cnt=0. filt_en dropped gives out=s on that edge and glitch_cnt unchanged.

Source files
------------

// File: rtl/pad_in_deglitch.sv
// Core-side conditioning for a raw pad input: synchronizer, optional stability
// filter, edge pulses and a saturating count of rejected glitches.
module pad_in_deglitch #(
   parameter int   SYNC_STAGES = 2,
   parameter int   CNT_W       = 8,
   parameter int   GLITCH_W    = 8,
   parameter logic RESET_VAL   = 1'b1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                i,
   input  logic                filt_en,
   input  logic [CNT_W-1:0]    stable_cycles,
   input  logic                glitch_clr,
   output logic                out,
   output logic                rise,
   output logic                fall,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   typedef enum logic {STABLE, QUALIFY} state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt, thr;
   logic [CNT_W:0]         cnt_inc;
   logic                   out_nxt, glitch_inc;
   logic [GLITCH_W-1:0]    glitch_nxt;

   // Plain flop chain; the pad level is asynchronous so nothing may sit between stages.
   always_ff @(posedge clock) begin
      if (!reset_n)
         sync <= {SYNC_STAGES{RESET_VAL}};
      else
         sync <= {sync[SYNC_STAGES-2:0], i};
   end

   assign s       = sync[SYNC_STAGES-1];
   assign thr     = (stable_cycles == '0) ? ONE : stable_cycles;
   assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

   // Threshold is re-read every cycle, so lowering it mid-qualification can finish it early.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      out_nxt    = out;
      glitch_inc = 1'b0;
      if (!filt_en) begin
         state_nxt = STABLE;
         cnt_nxt   = '0;
         out_nxt   = s;
      end else begin
         case (state)
            STABLE: begin
               if (s != out) begin
                  if (thr == ONE) begin
                     out_nxt = s;
                  end else begin
                     cnt_nxt   = ONE;
                     state_nxt = QUALIFY;
                  end
               end
            end
            QUALIFY: begin
               if (s == out) begin
                  cnt_nxt    = '0;
                  state_nxt  = STABLE;
                  glitch_inc = 1'b1;
               end else if (cnt_inc >= {1'b0, thr}) begin
                  out_nxt   = s;
                  cnt_nxt   = '0;
                  state_nxt = STABLE;
               end else begin
                  cnt_nxt = cnt_inc[CNT_W-1:0];
               end
            end
            default: begin
               cnt_nxt   = '0;
               state_nxt = STABLE;
            end
         endcase
      end
   end

   always_comb begin
      glitch_nxt = glitch_cnt;
      if (glitch_clr)
         glitch_nxt = '0;
      else if (glitch_inc && (glitch_cnt != {GLITCH_W{1'b1}}))
         glitch_nxt = glitch_cnt + GLITCH_W'(1);
   end

   // Pulses come from the same next-level decision as out, so they line up with it.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= STABLE;
         cnt        <= '0;
         out        <= RESET_VAL;
         rise       <= 1'b0;
         fall       <= 1'b0;
         glitch_cnt <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         out        <= out_nxt;
         rise       <= out_nxt & ~out;
         fall       <= ~out_nxt & out;
         glitch_cnt <= glitch_nxt;
      end
   end

endmodule

// File: tb/tb_pad_in_deglitch.sv
// Directed bench for pad_in_deglitch: vector table plus hand-written
// sequences for saturation, threshold change, filter drop and reset mid-qualify.
module tb_pad_in_deglitch;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       i, i0;
   logic       filt_en;
   logic [7:0] stable_cycles;
   logic       glitch_clr;
   logic       out, rise, fall;
   logic [7:0] glitch_cnt;
   logic       out0, rise0, fall0;
   logic [7:0] glitch_cnt0;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       i;
      logic       fe;
      logic [7:0] sc;
      logic       clr;
      logic       e_out;
      logic       e_rise;
      logic       e_fall;
      logic [7:0] e_glitch;
   } vec_t;

   vec_t vecs[$];

   pad_in_deglitch dut (
      .clock(clock), .reset_n(reset_n), .i(i), .filt_en(filt_en),
      .stable_cycles(stable_cycles), .glitch_clr(glitch_clr),
      .out(out), .rise(rise), .fall(fall), .glitch_cnt(glitch_cnt)
   );

   pad_in_deglitch #(.RESET_VAL(1'b0)) dut0 (
      .clock(clock), .reset_n(reset_n), .i(i0), .filt_en(filt_en),
      .stable_cycles(stable_cycles), .glitch_clr(glitch_clr),
      .out(out0), .rise(rise0), .fall(fall0), .glitch_cnt(glitch_cnt0)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic add(input logic vi, input logic fe, input logic [7:0] sc, input logic clr,
                      input logic eo, input logic er, input logic ef, input logic [7:0] eg);
      vec_t v;
      v.i = vi; v.fe = fe; v.sc = sc; v.clr = clr;
      v.e_out = eo; v.e_rise = er; v.e_fall = ef; v.e_glitch = eg;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      i             = v.i;
      filt_en       = v.fe;
      stable_cycles = v.sc;
      glitch_clr    = v.clr;
      tick();
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      check($sformatf("vec%0d.out", idx),    out,        v.e_out);
      check($sformatf("vec%0d.rise", idx),   rise,       v.e_rise);
      check($sformatf("vec%0d.fall", idx),   fall,       v.e_fall);
      check($sformatf("vec%0d.glitch", idx), glitch_cnt, v.e_glitch);
      check($sformatf("vec%0d.out0", idx),   {out0, rise0, fall0}, 3'b000);
      check($sformatf("vec%0d.glitch0", idx), glitch_cnt0, 8'd0);
   endtask

   // Holds lvl on the pad for three edges, then returns; the sixth edge is the abort.
   task automatic glitch_pulse(input logic lvl, input logic clr);
      i = lvl;
      repeat (3) tick();
      i = ~lvl;
      repeat (2) tick();
      glitch_clr = clr;
      tick();
      glitch_clr = 1'b0;
   endtask

   initial begin
      logic pulse_seen;
      reset_n = 1'b0; i = 1'b1; i0 = 1'b0;
      filt_en = 1'b0; stable_cycles = 8'd4; glitch_clr = 1'b0;

      for (int n = 0; n < 3; n++) begin
         tick();
         check("rst.out", out, 1'b1);
         check("rst.pulses", {rise, fall}, 2'b00);
         check("rst.glitch", glitch_cnt, 8'd0);
         check("rst.out0", out0, 1'b0);
      end
      reset_n = 1'b1;

      // bypass: fall after 3 edges, rise after 3 edges
      add(1,0,4,0, 1,0,0,0);
      add(0,0,4,0, 1,0,0,0);
      add(0,0,4,0, 1,0,0,0);
      add(0,0,4,0, 0,0,1,0);
      add(0,0,4,0, 0,0,0,0);
      add(1,0,4,0, 0,0,0,0);
      add(1,0,4,0, 0,0,0,0);
      add(1,0,4,0, 1,1,0,0);
      add(1,0,4,0, 1,0,0,0);
      // filter thr=4: 2+4 edges each direction
      add(0,1,4,0, 1,0,0,0);
      add(0,1,4,0, 1,0,0,0);
      add(0,1,4,0, 1,0,0,0);
      add(0,1,4,0, 1,0,0,0);
      add(0,1,4,0, 1,0,0,0);
      add(0,1,4,0, 0,0,1,0);
      add(0,1,4,0, 0,0,0,0);
      add(1,1,4,0, 0,0,0,0);
      add(1,1,4,0, 0,0,0,0);
      add(1,1,4,0, 0,0,0,0);
      add(1,1,4,0, 0,0,0,0);
      add(1,1,4,0, 0,0,0,0);
      add(1,1,4,0, 1,1,0,0);
      add(1,1,4,0, 1,0,0,0);
      // three-cycle low glitch
      add(0,1,4,0, 1,0,0,0);
      add(0,1,4,0, 1,0,0,0);
      add(0,1,4,0, 1,0,0,0);
      add(1,1,4,0, 1,0,0,0);
      add(1,1,4,0, 1,0,0,0);
      add(1,1,4,0, 1,0,0,1);
      add(1,1,4,0, 1,0,0,1);
      // thr 0 and 1 behave alike
      add(0,1,0,0, 1,0,0,1);
      add(0,1,0,0, 1,0,0,1);
      add(0,1,0,0, 0,0,1,1);
      add(0,1,0,0, 0,0,0,1);
      add(1,1,1,0, 0,0,0,1);
      add(1,1,1,0, 0,0,0,1);
      add(1,1,1,0, 1,1,0,1);
      add(1,1,1,0, 1,0,0,1);
      add(1,1,4,1, 1,0,0,0);
      add(1,1,4,0, 1,0,0,0);

      foreach (vecs[idx]) begin
         applyStimulus(vecs[idx]);
         checkOutput(idx, vecs[idx]);
      end

      // saturation over 300 glitches
      filt_en = 1'b1; stable_cycles = 8'd4;
      pulse_seen = 1'b0;
      for (int n = 0; n < 300; n++) begin
         glitch_pulse(1'b0, 1'b0);
         pulse_seen = pulse_seen | rise | fall;
      end
      check("sat.glitch", glitch_cnt, 8'd255);
      check("sat.out", out, 1'b1);
      check("sat.nopulse", pulse_seen, 1'b0);
      glitch_clr = 1'b1;
      tick();
      glitch_clr = 1'b0;
      check("clr.glitch", glitch_cnt, 8'd0);
      glitch_pulse(1'b0, 1'b0);
      check("one.glitch", glitch_cnt, 8'd1);
      glitch_pulse(1'b0, 1'b1);
      check("clrprio.glitch", glitch_cnt, 8'd0);
      tick();
      check("clrprio.hold", glitch_cnt, 8'd0);

      // threshold lowered 8 -> 2 while cnt=3
      stable_cycles = 8'd8;
      i = 1'b0;
      repeat (5) tick();
      check("thrdrop.before", out, 1'b1);
      stable_cycles = 8'd2;
      tick();
      check("thrdrop.out", out, 1'b0);
      check("thrdrop.fall", fall, 1'b1);
      tick();
      check("thrdrop.fall_low", fall, 1'b0);

      // filter dropped mid-qualify
      stable_cycles = 8'd8;
      glitch_pulse(1'b1, 1'b0);
      check("pre_fe.glitch", glitch_cnt, 8'd1);
      check("pre_fe.out", out, 1'b0);
      i = 1'b1;
      repeat (4) tick();
      check("fedrop.before", out, 1'b0);
      filt_en = 1'b0;
      tick();
      check("fedrop.out", out, 1'b1);
      check("fedrop.rise", rise, 1'b1);
      check("fedrop.glitch", glitch_cnt, 8'd1);
      tick();
      check("fedrop.rise_low", rise, 1'b0);

      // reset mid-qualify
      filt_en = 1'b1;
      i = 1'b0;
      repeat (4) tick();
      check("rstq.before", out, 1'b1);
      reset_n = 1'b0;
      i = 1'b1;
      tick();
      check("rstq.out", out, 1'b1);
      check("rstq.pulses", {rise, fall}, 2'b00);
      check("rstq.glitch", glitch_cnt, 8'd0);
      check("rstq.out0", out0, 1'b0);
      reset_n = 1'b1;
      pulse_seen = 1'b0;
      repeat (6) begin
         tick();
         pulse_seen = pulse_seen | rise | fall;
      end
      check("rstq.after_out", out, 1'b1);
      check("rstq.after_pulse", pulse_seen, 1'b0);
      check("rstq.after_glitch", glitch_cnt, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
